// File: rtl/tm_seq_ctrl.sv
// tm_seq_ctrl: APB3-programmed sequencer for the convolutional Tsetlin
// machine datapath (image load, per-patch clauses, class sum, result).
module tm_seq_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int PATCH_W    = 10,
  parameter int CLASS_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  load_req,
  input  logic                  load_done,
  output logic                  patch_start,
  output logic [PATCH_W-1:0]    patch_idx,
  input  logic                  patch_done,
  output logic                  sum_start,
  input  logic                  sum_done,
  input  logic [CLASS_W-1:0]    class_in,
  output logic                  abort,
  output logic                  irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PATCH,
    S_WAIT_P,
    S_SUM,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [PATCH_W-1:0] idx_q, idx_d;
  logic [PATCH_W-1:0] npatch_q, npatch_d;
  logic [PATCH_W-1:0] last_idx;
  logic [CLASS_W-1:0] result_q, result_d;
  logic [31:0]        cycles_q, cycles_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               abort_q, abort_d;
  logic               sent_q, sent_d;

  logic [2:0] addr;
  logic       acc, wr, rd, busy;
  logic       unmapped, wr_ctrl, wr_stat, wr_num, wr_ro;
  logic       start_req, abort_req, stray;
  logic       unused_bits;

  assign addr      = PADDR[4:2];
  assign acc       = PSEL & PENABLE;
  assign wr        = acc & PWRITE;
  assign rd        = PSEL & ~PWRITE;
  assign busy      = (state_q != S_IDLE);
  assign unmapped  = (addr > 3'd4);
  assign wr_ctrl   = wr & (addr == 3'd0);
  assign wr_stat   = wr & (addr == 3'd1);
  assign wr_num    = wr & (addr == 3'd2);
  assign wr_ro     = wr & ((addr == 3'd3) | (addr == 3'd4));
  assign start_req = wr_ctrl & PWDATA[0];
  assign abort_req = wr_ctrl & PWDATA[1];
  assign last_idx  = npatch_q - PATCH_W'(1);

  assign unused_bits = ^{PADDR[ADDR_WIDTH-1:5], PADDR[1:0], PWDATA};

  assign PREADY    = 1'b1;
  assign PSLVERR   = acc & (unmapped | wr_ro | (wr_num & busy));
  assign patch_idx = idx_q;
  assign abort     = abort_q;
  assign irq       = done_q & irq_en_q;

  assign stray = (load_done  & (state_q != S_LOAD))
               | (patch_done & (state_q != S_WAIT_P))
               | (sum_done   & (state_q != S_SUM));

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      case (addr)
        3'd0:    PRDATA = DATA_WIDTH'({irq_en_q, 2'b00});
        3'd1:    PRDATA = DATA_WIDTH'({err_q, done_q, busy});
        3'd2:    PRDATA = DATA_WIDTH'(npatch_q);
        3'd3:    PRDATA = DATA_WIDTH'(result_q);
        3'd4:    PRDATA = DATA_WIDTH'(cycles_q);
        default: PRDATA = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    npatch_d    = npatch_q;
    result_d    = result_q;
    cycles_d    = cycles_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    err_d       = err_q;
    abort_d     = 1'b0;
    sent_d      = 1'b0;
    load_req    = 1'b0;
    patch_start = 1'b0;
    sum_start   = 1'b0;

    if (busy && cycles_q != '1) cycles_d = cycles_q + 32'd1;
    if (wr_ctrl) irq_en_d = PWDATA[2];
    if (wr_num && !busy) npatch_d = PWDATA[PATCH_W-1:0];
    if (wr_stat && PWDATA[1]) done_d = 1'b0;
    if (wr_stat && PWDATA[2]) err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          if (npatch_q != '0) begin
            state_d  = S_LOAD;
            done_d   = 1'b0;
            cycles_d = '0;
            idx_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        load_req = 1'b1;
        if (load_done) state_d = S_PATCH;
      end
      S_PATCH: begin
        patch_start = 1'b1;
        state_d     = S_WAIT_P;
      end
      S_WAIT_P: begin
        if (patch_done) begin
          if (idx_q == last_idx) begin
            state_d = S_SUM;
          end else begin
            idx_d   = idx_q + PATCH_W'(1);
            state_d = S_PATCH;
          end
        end
      end
      S_SUM: begin
        // sent_q marks that the single sum_start pulse has gone out
        sum_start = ~sent_q;
        sent_d    = 1'b1;
        if (sum_done) begin
          result_d = class_in;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((start_req && busy) || stray) err_d = 1'b1;

    if (abort_req && busy) begin
      state_d  = S_IDLE;
      abort_d  = 1'b1;
      done_d   = done_q;
      result_d = result_q;
      idx_d    = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      npatch_q <= '0;
      result_q <= '0;
      cycles_q <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      npatch_q <= npatch_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
      sent_q   <= sent_d;
    end
  end

endmodule

// File: tb/tb_tm_seq_ctrl.sv
// Bench for tm_seq_ctrl: APB-driven runs against a latency-programmable
// datapath responder and an arithmetic timing/ordering model.
module tb_tm_seq_ctrl;

  localparam int PW = 10;
  localparam int CW = 4;
  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_STAT = 32'h04;
  localparam logic [31:0] A_NUM  = 32'h08;
  localparam logic [31:0] A_RES  = 32'h0C;
  localparam logic [31:0] A_CYC  = 32'h10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   PADDR, PWDATA, PRDATA;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic          load_req, load_done, patch_start, patch_done;
  logic          sum_start, sum_done, abort, irq;
  logic [PW-1:0] patch_idx;
  logic [CW-1:0] class_in;

  int            checks = 0;
  int            errors = 0;
  int            lat_l = 1, lat_p = 1, lat_s = 1;
  logic [CW-1:0] cls_v = '0;
  logic [CW-1:0] last_cls = '0;
  int            n_sum = 0, n_abort = 0, n_load = 0;
  int            inj_req = 0, inj_ack = 0;
  int            seen[$];

  always #5 clk = ~clk;

  tm_seq_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PATCH_W(PW), .CLASS_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .load_req(load_req), .load_done(load_done),
    .patch_start(patch_start), .patch_idx(patch_idx),
    .patch_done(patch_done), .sum_start(sum_start), .sum_done(sum_done),
    .class_in(class_in), .abort(abort), .irq(irq)
  );

  // datapath responder: answers each request after the programmed latency
  initial begin
    int lc, pc, sc;
    lc = 0; pc = 0; sc = 0;
    load_done = 1'b0; patch_done = 1'b0; sum_done = 1'b0; class_in = '0;
    forever begin
      @(negedge clk);
      load_done = 1'b0; patch_done = 1'b0; sum_done = 1'b0;
      if (!rst_n) begin
        lc = 0; pc = 0; sc = 0;
      end else if (abort) begin
        n_abort++;
        lc = 0; pc = 0; sc = 0;
      end else begin
        if (load_req) begin
          n_load++;
          lc++;
          if (lc == lat_l) begin load_done = 1'b1; lc = 0; end
        end else lc = 0;
        if (patch_start) begin
          seen.push_back(int'(patch_idx));
          pc = lat_p;
        end else if (pc > 0) begin
          pc--;
          if (pc == 0) patch_done = 1'b1;
        end
        if (sum_start) begin
          n_sum++;
          sc = lat_s;
        end else if (sc > 0) begin
          sc--;
          if (sc == 0) begin sum_done = 1'b1; class_in = cls_v; end
        end
        if (inj_req != inj_ack) begin
          inj_ack  = inj_req;
          sum_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d,
                        output logic e);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 e = PSLVERR;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] r,
                        output logic e);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge clk);
    PENABLE = 1'b1;
    #1 begin r = PRDATA; e = PSLVERR; end
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] r;
    logic        e;
    int          k;
    k = 0;
    do begin
      apb_rd(A_STAT, r, e);
      k++;
    end while (r[0] && k < 500);
    chk({tag, " busy"}, {31'b0, r[0]}, 32'd0);
  endtask

  // full run; busy cycles = load + n*(patch+1) + (sum+1) + done cycle
  task automatic run(input int n, input int l, input int p, input int s,
                     input logic [CW-1:0] c, input string tag);
    logic [31:0] r;
    logic        e;
    int          n0;
    lat_l = l; lat_p = p; lat_s = s; cls_v = c;
    seen.delete();
    n0 = n_sum;
    apb_wr(A_NUM, 32'(n), e);
    apb_wr(A_CTRL, 32'h5, e);
    wait_idle(tag);
    apb_rd(A_STAT, r, e);
    chk({tag, " status"}, r, 32'h2);
    apb_rd(A_RES, r, e);
    chk({tag, " result"}, r, 32'(c));
    apb_rd(A_CYC, r, e);
    chk({tag, " cycles"}, r, 32'(l + n * (p + 1) + s + 2));
    chk({tag, " sum_starts"}, 32'(n_sum - n0), 32'd1);
    chk({tag, " patches"}, 32'(seen.size()), 32'(n));
    for (int i = 0; i < seen.size(); i++)
      chk($sformatf("%s idx%0d", tag, i), 32'(seen[i]), 32'(i));
    chk({tag, " irq"}, 32'(irq), 32'd1);
    apb_wr(A_STAT, 32'h2, e);
    #1 chk({tag, " irq clr"}, 32'(irq), 32'd0);
    last_cls = c;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          k, n0, a0;
    rst_n = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (3) @(negedge clk);
    chk("rst pready", 32'(PREADY), 32'd1);
    chk("rst irq", 32'(irq), 32'd0);
    chk("rst load_req", 32'(load_req), 32'd0);
    chk("rst prdata", PRDATA, 32'd0);
    rst_n = 1'b1;

    apb_rd(A_CTRL, r, e); chk("rst ctrl", r, 32'd0);
    apb_rd(A_STAT, r, e); chk("rst status", r, 32'd0);
    apb_rd(A_NUM, r, e);  chk("rst num", r, 32'd0);
    apb_rd(A_RES, r, e);  chk("rst result", r, 32'd0);
    apb_rd(A_CYC, r, e);  chk("rst cycles", r, 32'd0);

    // error cases
    apb_wr(A_CTRL, 32'h1, e);
    apb_rd(A_STAT, r, e); chk("start np0 status", r, 32'h4);
    chk("start np0 no load", 32'(n_load), 32'd0);
    apb_rd(32'h14, r, e);
    chk("unmapped slverr", 32'(e), 32'd1);
    chk("unmapped prdata", r, 32'd0);
    apb_wr(32'h18, 32'hFF, e); chk("unmapped wr slverr", 32'(e), 32'd1);
    apb_wr(A_RES, 32'h3, e);   chk("ro wr slverr", 32'(e), 32'd1);
    apb_rd(A_RES, r, e);       chk("ro wr ignored", r, 32'd0);
    apb_wr(A_STAT, 32'h4, e);
    apb_rd(A_STAT, r, e);      chk("err w1c", r, 32'd0);
    inj_req++;
    repeat (3) @(negedge clk);
    apb_rd(A_STAT, r, e);      chk("stray sum_done err", r, 32'h4);
    apb_wr(A_STAT, 32'h4, e);

    // normal run and the single-patch boundary
    run(3, 5, 4, 3, 4'd7, "normal");
    run(1, 1, 1, 1, 4'd15, "n1");

    // busy protection
    lat_l = 3; lat_p = 12; lat_s = 2; cls_v = 4'd9;
    seen.delete();
    apb_wr(A_NUM, 32'd2, e);
    apb_wr(A_CTRL, 32'h5, e);
    repeat (6) @(negedge clk);
    apb_wr(A_NUM, 32'd9, e); chk("num busy slverr", 32'(e), 32'd1);
    apb_rd(A_NUM, r, e);     chk("num held", r, 32'd2);
    apb_wr(A_CTRL, 32'h5, e);
    apb_rd(A_STAT, r, e);    chk("start busy err", r, 32'h5);
    wait_idle("busy run");
    apb_rd(A_STAT, r, e);    chk("busy run status", r, 32'h6);
    apb_rd(A_RES, r, e);     chk("busy run result", r, 32'd9);
    apb_rd(A_CYC, r, e);     chk("busy run cycles", r, 32'd33);
    chk("busy run patches", 32'(seen.size()), 32'd2);
    apb_wr(A_STAT, 32'h6, e);
    last_cls = 4'd9;

    // abort during patch 1 of 4
    lat_l = 2; lat_p = 8; lat_s = 2; cls_v = 4'd3;
    a0 = n_abort;
    apb_wr(A_NUM, 32'd4, e);
    apb_wr(A_CTRL, 32'h5, e);
    k = 0;
    while (patch_idx != PW'(1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("abort reach p1", 32'(patch_idx), 32'd1);
    apb_wr(A_CTRL, 32'h6, e);
    #1 chk("abort pulse", 32'(abort), 32'd1);
    @(negedge clk);
    #1 chk("abort width", 32'(abort), 32'd0);
    apb_rd(A_STAT, r, e);    chk("abort status", r, 32'd0);
    chk("abort count", 32'(n_abort - a0), 32'd1);
    apb_rd(A_RES, r, e);     chk("abort result kept", r, 32'(last_cls));
    run(4, 2, 3, 2, 4'd11, "post abort");

    // W1C DONE on the exact edge DONE is set (T = 2 + 2*3 + 2 + 2)
    lat_l = 2; lat_p = 2; lat_s = 2; cls_v = 4'd5;
    apb_wr(A_NUM, 32'd2, e);
    apb_wr(A_CTRL, 32'h1, e);
    repeat (12 - 3) @(negedge clk);
    apb_wr(A_STAT, 32'h2, e);
    apb_rd(A_STAT, r, e);    chk("done set wins", r, 32'h2);
    chk("irq gated off", 32'(irq), 32'd0);
    apb_wr(A_STAT, 32'h2, e);

    // randomized runs
    for (int i = 0; i < 5; i++)
      run(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
          int'($urandom_range(1, 5)), int'($urandom_range(1, 5)),
          CW'($urandom_range(0, 15)), $sformatf("rnd%0d", i));

    // reset in the middle of LOAD
    lat_l = 20;
    n0 = n_abort;
    apb_wr(A_NUM, 32'd2, e);
    apb_wr(A_CTRL, 32'h1, e);
    repeat (3) @(negedge clk);
    chk("mid load req", 32'(load_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst async load_req", 32'(load_req), 32'd0);
    chk("rst async patch_idx", 32'(patch_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apb_rd(A_STAT, r, e);    chk("rst idle status", r, 32'd0);
    apb_rd(A_NUM, r, e);     chk("rst num cleared", r, 32'd0);
    chk("rst no abort", 32'(n_abort - n0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tm_seq_ctrl.md
Name: tm_seq_ctrl

Overview:
- APB3-programmed sequencer for the convolutional Tsetlin machine inference datapath.
- Software writes the run configuration, then sets START. The block loads the image, walks every patch through clause evaluation, triggers class summation, and captures the predicted class.
- Completion is reported through the sticky DONE flag and the irq output.
- Sits between the APB3 control path and the datapath engines.

Parameters:
ADDR_WIDTH, 32, APB address width (only PADDR[4:2] decoded)
DATA_WIDTH, 32, APB data width
PATCH_W, 10, width of patch count/index
CLASS_W, 4, width of predicted class index

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
PADDR  in  ADDR_WIDTH  APB address
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB write
PWDATA  in  DATA_WIDTH  APB write data
PRDATA  out  DATA_WIDTH  APB read data
PREADY  out  1  always 1
PSLVERR  out  1  error response, valid in access phase
load_req  out  1  level, image load request
load_done  in  1  1-cycle pulse, image buffered
patch_start  out  1  1-cycle pulse
patch_idx  out  PATCH_W  current patch index
patch_done  in  1  1-cycle pulse
sum_start  out  1  1-cycle pulse
sum_done  in  1  1-cycle pulse
class_in  in  CLASS_W  argmax result, valid with sum_done
abort  out  1  1-cycle pulse on software abort
irq  out  1  DONE & IRQ_EN, level

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except PREADY = 1; all registers 0; FSM in IDLE.
- APB: zero wait states. A write takes effect on the rising edge where PSEL & PENABLE & PWRITE. PRDATA is combinational from the decode and is 0 when not reading.
- Register map:
  - 0x00 CTRL: bit0 START (W1, self-clearing, reads 0), bit1 ABORT (W1, reads 0), bit2 IRQ_EN (RW).
  - 0x04 STATUS: bit0 BUSY (RO), bit1 DONE (sticky, W1C), bit2 ERR (sticky, W1C).
  - 0x08 NUM_PATCH [PATCH_W-1:0] RW.
  - 0x0C RESULT [CLASS_W-1:0] RO.
  - 0x10 CYCLES [31:0] RO: clk count from START accept to DONE, saturating at 0xFFFFFFFF.
- PSLVERR = 1 in the following cases; the write is ignored:
  - Any access to an unmapped offset (0x14 and above). PRDATA = 0 for reads.
  - A write to NUM_PATCH while BUSY.
  - A write to a RO register.
- FSM states IDLE, LOAD, PATCH, WAIT_P, SUM, DONE:
  - IDLE: START with NUM_PATCH != 0 -> LOAD. The same edge clears DONE and CYCLES and sets patch_idx = 0. START with NUM_PATCH == 0 -> set ERR, stay IDLE.
  - LOAD: load_req = 1 until load_done. On load_done -> PATCH.
  - PATCH: pulse patch_start for one cycle -> WAIT_P.
  - WAIT_P: on patch_done, if patch_idx == NUM_PATCH-1 -> SUM; else patch_idx += 1 -> PATCH.
  - SUM: pulse sum_start on entry, wait for sum_done. On sum_done, RESULT <= class_in -> DONE.
  - DONE: set DONE (one cycle) -> IDLE.
- BUSY = (state != IDLE) and counts as busy in DONE.
- START while BUSY is ignored and sets ERR.
- ABORT while BUSY: next state IDLE, abort pulsed for 1 cycle, load_req dropped, DONE not set, RESULT unchanged. ABORT in IDLE has no effect.
- Stray handshakes: load_done, patch_done or sum_done arriving in a state that is not waiting for it is ignored and sets ERR.
- A W1C write to DONE in the same cycle that DONE is being set leaves DONE = 1 (set wins).
- Reset mid-run returns immediately to IDLE with all outputs cleared. No abort pulse is issued on reset.
- CYCLES increments every cycle while BUSY.

Test Plan:
1. Reset, then read all registers -> 0; PREADY = 1, irq = 0.
2. Normal run:
   - Stimulus: NUM_PATCH = 3, IRQ_EN = 1, START; datapath model answers load_done after 5 cycles, patch_done 4 cycles after each patch_start, sum_done with class_in = 7.
   - Required response: patch_idx sequence 0, 1, 2; one sum_start; RESULT = 7; DONE = 1; irq = 1; CYCLES equals the measured count. W1C DONE -> irq = 0.
3. Error cases:
   - START with NUM_PATCH = 0 -> ERR = 1, BUSY stays 0, no load_req.
   - Read at 0x14 -> PSLVERR = 1, PRDATA = 0.
4. Busy protection: NUM_PATCH = 2, START, then write NUM_PATCH = 9 during WAIT_P -> PSLVERR = 1, NUM_PATCH reads 2; second START -> ERR = 1, run completes normally.
5. Abort: ABORT during patch 1 of 4 -> abort pulse exactly 1 cycle, BUSY = 0 the next cycle, DONE = 0; a subsequent START completes a full run.
6. Edge cases:
   - W1C DONE in the same cycle as the DONE set -> DONE reads 1.
   - Assert rst_n = 0 mid-LOAD -> load_req drops asynchronously, FSM in IDLE.
